// File: rtl/vga_avn_pkg.sv
// Shared constants for the VGA Avalon-MM arbiter and the tops that instantiate it.
package vga_avn_pkg;
    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;
endpackage

// File: rtl/vga_fifo.sv
// Small synchronous FIFO. Here it holds the port tags of reads that have been issued
// and not yet answered.
module vga_fifo #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_data  = r_mem[r_rd_ptr];
    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples the pre-edge values and simulation matches the synthesized flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= ptr_next(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= ptr_next(r_rd_ptr);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: the storage array is deliberately not reset; pointers and count decide which
    // entries are valid, and leaving it unreset lets it map onto plain RAM/LUT storage.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_data;
    end
endmodule

// File: rtl/vga_avn_arbiter.sv
// N-port Avalon-MM arbiter in front of one memory port: fixed-priority or round-robin
// grant, grant lock across waitrequest, and tag-FIFO routing of read responses.
module vga_avn_arbiter
    import vga_avn_pkg::*;
#(
    parameter int AVN_AW       = 18,
    parameter int AVN_DW       = 16,
    parameter int NPORT        = 2,
    parameter int PENDING_READ = 4,
    parameter int ARB_MODE     = ARB_FIXED
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NPORT-1:0]            port_avn_read,
    input  logic [NPORT-1:0]            port_avn_write,
    input  logic [NPORT*AVN_AW-1:0]     port_avn_address,
    input  logic [NPORT*AVN_DW-1:0]     port_avn_writedata,
    input  logic [NPORT*(AVN_DW/8)-1:0] port_avn_byteenable,
    output logic [NPORT-1:0]            port_avn_waitrequest,
    output logic [NPORT-1:0]            port_avn_readdatavalid,
    output logic [AVN_DW-1:0]           port_avn_readdata,
    output logic                        out_avn_read,
    output logic                        out_avn_write,
    output logic [AVN_AW-1:0]           out_avn_address,
    output logic [AVN_DW-1:0]           out_avn_writedata,
    output logic [AVN_DW/8-1:0]         out_avn_byteenable,
    input  logic [AVN_DW-1:0]           out_avn_readdata,
    input  logic                        out_avn_readdatavalid,
    input  logic                        out_avn_waitrequest,
    output logic                        err_orphan_rsp
);
    localparam int PW = $clog2(NPORT);
    localparam int BW = AVN_DW / 8;

    logic             w_fifo_full;
    logic             w_fifo_empty;
    logic [PW-1:0]    w_fifo_head;
    logic [NPORT-1:0] w_eligible;
    logic [PW-1:0]    w_winner;
    logic [PW-1:0]    w_idx;
    logic             w_found;
    logic [PW-1:0]    w_grant;
    logic             w_active;
    logic             w_req;
    logic             w_accept;
    logic             r_grant_lock;
    logic [PW-1:0]    r_grant_id;
    logic [PW-1:0]    r_rr_ptr;
    logic             r_err_orphan;

    function automatic logic [PW-1:0] port_next(input logic [PW-1:0] p);
        return (p == PW'(NPORT - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_eligible = port_avn_write | (port_avn_read & {NPORT{~w_fifo_full}});

    // NOTE: every variable gets a default at the top of the block so no path leaves
    // one unassigned, which would otherwise infer a latch.
    always_comb begin
        w_winner = '0;
        w_found  = 1'b0;
        w_idx    = r_rr_ptr;
        if (ARB_MODE == ARB_RR) begin
            for (int k = 0; k < NPORT; k++) begin
                if (!w_found && w_eligible[w_idx]) begin
                    w_winner = w_idx;
                    w_found  = 1'b1;
                end
                w_idx = port_next(w_idx);
            end
        end else begin
            for (int i = 0; i < NPORT; i++) begin
                if (w_eligible[i]) w_winner = PW'(i);
            end
        end
    end

    // A stalled grant stays with its port until the memory accepts it.
    assign w_grant  = r_grant_lock ? r_grant_id : w_winner;
    assign w_active = r_grant_lock | (|w_eligible);

    assign out_avn_read       = w_active & port_avn_read[w_grant];
    assign out_avn_write      = w_active & port_avn_write[w_grant];
    assign out_avn_address    = port_avn_address[w_grant*AVN_AW +: AVN_AW];
    assign out_avn_writedata  = port_avn_writedata[w_grant*AVN_DW +: AVN_DW];
    assign out_avn_byteenable = port_avn_byteenable[w_grant*BW +: BW];

    assign w_req    = out_avn_read | out_avn_write;
    assign w_accept = w_req & ~out_avn_waitrequest;

    always_comb begin
        port_avn_waitrequest   = '1;
        port_avn_readdatavalid = '0;
        for (int i = 0; i < NPORT; i++) begin
            port_avn_waitrequest[i]   = ~(w_active & (w_grant == PW'(i))) | out_avn_waitrequest
                                        | (port_avn_read[i] & w_fifo_full);
            port_avn_readdatavalid[i] = out_avn_readdatavalid & ~w_fifo_empty
                                        & (w_fifo_head == PW'(i));
        end
    end

    assign port_avn_readdata = out_avn_readdata;
    assign err_orphan_rsp    = r_err_orphan;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_grant_lock <= 1'b0;
            r_grant_id   <= '0;
            r_rr_ptr     <= '0;
            r_err_orphan <= 1'b0;
        end else begin
            r_grant_lock <= w_req & out_avn_waitrequest;
            if (w_req & out_avn_waitrequest) r_grant_id <= w_grant;
            if (w_accept && (ARB_MODE == ARB_RR)) r_rr_ptr <= port_next(w_grant);
            if (out_avn_readdatavalid & w_fifo_empty) r_err_orphan <= 1'b1;
        end
    end

    vga_fifo #(
        .WIDTH (PW),
        .DEPTH (PENDING_READ)
    ) u_tag_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_accept & out_avn_read),
        .i_data  (w_grant),
        .i_pop   (out_avn_readdatavalid),
        .o_data  (w_fifo_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );
endmodule

// File: tb/tb_vga_avn_arbiter.sv
// Bench: a fixed-priority and a round-robin arbiter (3 ports, 4 pending reads) share one
// directed stimulus; a queue-level model checks both every cycle, literals pin the model.
module tb_vga_avn_arbiter;
    import vga_avn_pkg::*;

    localparam int NP = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [2:0]    rd, wr;
    logic [53:0]   addr_bus;
    logic [47:0]   wdata_bus;
    logic [5:0]    be_bus;
    logic          mem_wait, mem_rvalid;
    logic [15:0]   mem_rdata;

    logic [2:0]    wreq_o  [2];
    logic [2:0]    rv_o    [2];
    logic [15:0]   rdata_o [2];
    logic          ord_o   [2];
    logic          owr_o   [2];
    logic [17:0]   oaddr_o [2];
    logic [15:0]   owd_o   [2];
    logic [1:0]    obe_o   [2];
    logic          err_o   [2];

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [17:0] A0 = 18'h00123, A1 = 18'h2ABCD, A2 = 18'h3F00F;

    // Model state, index 0 = fixed-priority instance, 1 = round-robin instance.
    bit m_lock [2];
    int m_lock_id [2];
    int m_rr [2];
    int m_tags [2][4];
    int m_cnt [2];
    bit m_err [2];

    always #5 clk = ~clk;

    vga_avn_arbiter #(.AVN_AW(18), .AVN_DW(16), .NPORT(NP), .PENDING_READ(4),
                      .ARB_MODE(ARB_FIXED)) dut_fx (
        .clk(clk), .rst(rst),
        .port_avn_read(rd), .port_avn_write(wr), .port_avn_address(addr_bus),
        .port_avn_writedata(wdata_bus), .port_avn_byteenable(be_bus),
        .port_avn_waitrequest(wreq_o[0]), .port_avn_readdatavalid(rv_o[0]),
        .port_avn_readdata(rdata_o[0]),
        .out_avn_read(ord_o[0]), .out_avn_write(owr_o[0]), .out_avn_address(oaddr_o[0]),
        .out_avn_writedata(owd_o[0]), .out_avn_byteenable(obe_o[0]),
        .out_avn_readdata(mem_rdata), .out_avn_readdatavalid(mem_rvalid),
        .out_avn_waitrequest(mem_wait), .err_orphan_rsp(err_o[0])
    );

    vga_avn_arbiter #(.AVN_AW(18), .AVN_DW(16), .NPORT(NP), .PENDING_READ(4),
                      .ARB_MODE(ARB_RR)) dut_rr (
        .clk(clk), .rst(rst),
        .port_avn_read(rd), .port_avn_write(wr), .port_avn_address(addr_bus),
        .port_avn_writedata(wdata_bus), .port_avn_byteenable(be_bus),
        .port_avn_waitrequest(wreq_o[1]), .port_avn_readdatavalid(rv_o[1]),
        .port_avn_readdata(rdata_o[1]),
        .out_avn_read(ord_o[1]), .out_avn_write(owr_o[1]), .out_avn_address(oaddr_o[1]),
        .out_avn_writedata(owd_o[1]), .out_avn_byteenable(obe_o[1]),
        .out_avn_readdata(mem_rdata), .out_avn_readdatavalid(mem_rvalid),
        .out_avn_waitrequest(mem_wait), .err_orphan_rsp(err_o[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic bit bitof(input logic [2:0] v, input int j);
        return ((v >> j) & 3'b001) != 3'b000;
    endfunction

    // One cycle of the model for instance m: expected outputs, then the next state.
    task automatic model_cycle(input int m);
        bit          full, act, acc;
        logic [2:0]  elig, e_wreq, e_rv;
        logic        e_rd, e_wr;
        int          g, j;
        string       p;
        p = (m == 0) ? "fx" : "rr";
        if (rst) begin
            m_lock[m] = 0; m_lock_id[m] = 0; m_rr[m] = 0; m_cnt[m] = 0; m_err[m] = 0;
        end
        full = (m_cnt[m] == 4);
        elig = wr | (rd & {3{~full}});
        act  = 0;
        g    = 0;
        if (m_lock[m]) begin
            act = 1; g = m_lock_id[m];
        end else if (elig != 3'b000) begin
            act = 1;
            if (m == 0) begin
                for (int i = 0; i < NP; i++) if (bitof(elig, i)) g = i;
            end else begin
                for (int k = NP - 1; k >= 0; k--) begin
                    j = (m_rr[m] + k) % NP;
                    if (bitof(elig, j)) g = j;
                end
            end
        end
        e_rd = act & bitof(rd, g);
        e_wr = act & bitof(wr, g);
        e_wreq = 3'b000;
        for (int i = 0; i < NP; i++)
            if (!(act && g == i) || mem_wait || (bitof(rd, i) && full)) e_wreq |= 3'(1 << i);
        e_rv = (mem_rvalid && m_cnt[m] > 0) ? 3'(1 << m_tags[m][0]) : 3'b000;

        check({p, "_out_read"}, ord_o[m], e_rd);
        check({p, "_out_write"}, owr_o[m], e_wr);
        if (e_rd || e_wr) begin
            check({p, "_out_address"}, oaddr_o[m], addr_bus[g*18 +: 18]);
            check({p, "_out_byteenable"}, obe_o[m], be_bus[g*2 +: 2]);
        end
        if (e_wr) check({p, "_out_writedata"}, owd_o[m], wdata_bus[g*16 +: 16]);
        check({p, "_waitrequest"}, wreq_o[m], e_wreq);
        check({p, "_readdatavalid"}, rv_o[m], e_rv);
        if (e_rv != 3'b000) check({p, "_readdata"}, rdata_o[m], mem_rdata);
        check({p, "_err_orphan"}, err_o[m], m_err[m]);

        if (!rst) begin
            acc = (e_rd || e_wr) && !mem_wait;
            m_lock[m] = (e_rd || e_wr) && mem_wait;
            if (m_lock[m]) m_lock_id[m] = g;
            if (acc && m == 1) m_rr[m] = (g + 1) % NP;
            if (mem_rvalid) begin
                if (m_cnt[m] > 0) begin
                    for (int i = 0; i < 3; i++) m_tags[m][i] = m_tags[m][i+1];
                    m_cnt[m]--;
                end else begin
                    m_err[m] = 1;
                end
            end
            if (acc && e_rd) begin
                m_tags[m][m_cnt[m]] = g;
                m_cnt[m]++;
            end
        end
    endtask

    always @(negedge clk) begin
        model_cycle(0);
        model_cycle(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
        mem_rdata = mem_rdata + 16'h0111;
    endtask

    int          cnt [3];
    logic [2:0]  exp_v;

    initial begin
        rst = 1'b1; rd = '0; wr = '0; mem_wait = 1'b0; mem_rvalid = 1'b0; mem_rdata = 16'h1000;
        addr_bus  = {A2, A1, A0};
        wdata_bus = {16'hC3C3, 16'h5A5A, 16'hA5A5};
        be_bus    = {2'b11, 2'b10, 2'b01};
        repeat (2) @(posedge clk);
        #3;
        check("reset_fx_waitrequest", wreq_o[0], 3'b111);
        check("reset_rr_out_read", ord_o[1], 1'b0);
        check("reset_fx_err", err_o[0], 1'b0);
        tick(); rst = 1'b0;

        // Ports 0 and 2 read together.
        rd = 3'b101; #2;
        check("t1_fx_first_addr", oaddr_o[0], A2);
        check("t1_fx_waitrequest", wreq_o[0], 3'b011);
        check("t1_rr_first_addr", oaddr_o[1], A0);
        tick(); rd = 3'b001; #2;
        check("t1_fx_second_addr", oaddr_o[0], A0);
        tick(); rd = 3'b000; mem_rvalid = 1'b1; #2;
        check("t1_fx_rvalid0", rv_o[0], 3'b100);
        check("t1_rr_rvalid0", rv_o[1], 3'b001);
        tick(); #2;
        check("t1_fx_rvalid1", rv_o[0], 3'b001);
        tick(); mem_rvalid = 1'b0;

        // Fresh pointer, then all ports write continuously.
        rst = 1'b1; tick(); rst = 1'b0;
        cnt = '{0, 0, 0};
        wr = 3'b111;
        for (int c = 0; c < 6; c++) begin
            #2;
            exp_v = 3'b111 ^ (3'b001 << (c % 3));
            check("t2_rr_grant", wreq_o[1], exp_v);
            check("t2_fx_grant", wreq_o[0], 3'b011);
            for (int i = 0; i < NP; i++) if (!bitof(wreq_o[1], i)) cnt[i]++;
            tick();
        end
        wr = 3'b000;
        for (int i = 0; i < NP; i++) check("t2_rr_share", cnt[i], 2);

        // Port 1 stalls three cycles; port 2 arrives mid-stall.
        wr = 3'b010; mem_wait = 1'b1; #2;
        check("t3_fx_addr_c1", oaddr_o[0], A1);
        tick(); wr = 3'b110; #2;
        check("t3_fx_addr_c2", oaddr_o[0], A1);
        check("t3_rr_addr_c2", oaddr_o[1], A1);
        check("t3_fx_wait_c2", wreq_o[0], 3'b111);
        tick(); #2;
        check("t3_fx_addr_c3", oaddr_o[0], A1);
        tick(); mem_wait = 1'b0; #2;
        check("t3_fx_accept", wreq_o[0], 3'b101);
        tick(); wr = 3'b100; #2;
        check("t3_fx_next", oaddr_o[0], A2);
        check("t3_rr_next", oaddr_o[1], A2);
        tick(); wr = 3'b000;

        // Fill the four-deep read tag FIFO, then a read is held off while a write passes.
        rd = 3'b001; tick(); rd = 3'b010; tick(); rd = 3'b100; tick(); rd = 3'b001; #2;
        check("t4_fx_fourth_read", ord_o[0], 1'b1);
        tick(); rd = 3'b010; wr = 3'b100; #2;
        check("t4_fx_read_masked", ord_o[0], 1'b0);
        check("t4_fx_write_passes", owr_o[0], 1'b1);
        check("t4_fx_waitrequest", wreq_o[0], 3'b011);
        check("t4_rr_write_addr", oaddr_o[1], A2);
        tick(); wr = 3'b000; #2;
        check("t4_fx_still_full", wreq_o[0], 3'b111);
        tick(); rd = 3'b000; mem_rvalid = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #2;
            exp_v = 3'b001 << (c % 3);
            check("t4_fx_route", rv_o[0], exp_v);
            check("t4_rr_route", rv_o[1], exp_v);
            tick();
        end

        // Response with nothing outstanding.
        #2;
        check("t5_fx_no_valid", rv_o[0], 3'b000);
        check("t5_fx_err_before", err_o[0], 1'b0);
        tick(); mem_rvalid = 1'b0; #2;
        check("t5_fx_err_set", err_o[0], 1'b1);
        check("t5_rr_err_set", err_o[1], 1'b1);
        tick(); tick(); #2;
        check("t5_fx_err_sticky", err_o[0], 1'b1);

        // Reset between edges with two reads pending and a locked write.
        tick(); rd = 3'b001; tick(); rd = 3'b010; tick();
        rd = 3'b000; wr = 3'b100; mem_wait = 1'b1; tick();
        #2; rst = 1'b1; mem_rvalid = 1'b1; #1;
        check("t6_fx_rvalid_in_reset", rv_o[0], 3'b000);
        check("t6_rr_rvalid_in_reset", rv_o[1], 3'b000);
        check("t6_fx_err_cleared", err_o[0], 1'b0);
        check("t6_rr_err_cleared", err_o[1], 1'b0);
        tick(); rst = 1'b0; #2;
        check("t6_fx_lost_response", rv_o[0], 3'b000);
        tick(); mem_rvalid = 1'b0; wr = 3'b000; mem_wait = 1'b0; #2;
        check("t6_fx_orphan_after", err_o[0], 1'b1);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
